// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// captures the returned word into IR under a req/valid/ack handshake and
// computes the next PC (PC+4, branch, jump, jr) from the captured IR.
//
// state | meaning
// IDLE  | no fetch in flight, IR empty (or already acknowledged)
// WAIT  | PC held stable while memory settles; IR captured when cnt reaches 0
// VALID | IR holds an unconsumed instruction, waiting for ir_ack
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_req,
  input  logic        ir_ack,
  input  logic        pc_we,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        busy,
  output logic        fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  cnt;
  logic [31:0] pc_plus4;
  logic [31:0] ir_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] pc_nxt;
  logic        accept_req;
  logic        capture;
  logic        pc_wr;

  assign pc_plus4    = pc + 32'd4;
  assign ir_pc_plus4 = ir_pc + 32'd4;
  assign br_offset   = {{14{ir[15]}}, ir[15:0], 2'b00};

  // The PC must not move while memory is being read, so WAIT blocks writes.
  assign accept_req = (state == IDLE) && fetch_req && !stall;
  assign capture    = (state == WAIT) && (cnt == 4'd0);
  assign pc_wr      = pc_we && !stall && (state != WAIT);

  // Next-PC select; branch and jump are relative to the fetched instruction.
  always_comb begin
    pc_nxt = pc_plus4;
    case (pc_src)
      2'b00:   pc_nxt = pc_plus4;
      2'b01:   pc_nxt = ir_pc_plus4 + br_offset;
      2'b10:   pc_nxt = {ir_pc_plus4[31:28], ir[25:0], 2'b00};
      default: pc_nxt = jr_target;
    endcase
  end

  // Fetch handshake state transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_req) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = VALID;
      VALID:   if (ir_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter and the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == WAIT);
      ir_valid <= (state_nxt == VALID);
      if (accept_req) begin
        cnt <= LAT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Capture the instruction word and the PC it came from.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir    <= 32'd0;
      ir_pc <= 32'd0;
    end else if (capture) begin
      ir    <= imem_rdata;
      ir_pc <= pc;
    end
  end

  // PC update; a misaligned target leaves the PC alone and latches fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else if (pc_wr) begin
      if (pc_nxt[1:0] != 2'b00) begin
        fault <= 1'b1;
      end else begin
        pc <= pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: one instance with zero memory latency and one with
// latency 3 and a non-zero reset PC. Expected fetch results are queued when a
// fetch is requested and compared when the DUT raises ir_valid.
module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] ir_pc;
  } fetch_t;

  localparam logic [31:0] RST_PC3 = 32'h0000_0020;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] jr_target;

  logic        fetch_req0, ir_ack0, pc_we0;
  logic [31:0] imem_rdata0, pc0, ir0, ir_pc0;
  logic        ir_valid0, busy0, fault0;

  logic        fetch_req3, ir_ack3, pc_we3;
  logic [31:0] imem_rdata3, pc3, ir3, ir_pc3;
  logic        ir_valid3, busy3, fault3;

  logic [31:0] imem [0:63];
  fetch_t      sb [$];
  int          checks;
  int          errors;

  assign imem_rdata0 = imem[pc0[7:2]];
  assign imem_rdata3 = imem[pc3[7:2]];

  ifetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_req(fetch_req0), .ir_ack(ir_ack0),
    .pc_we(pc_we0), .pc_src(pc_src), .jr_target(jr_target), .imem_rdata(imem_rdata0),
    .pc(pc0), .ir(ir0), .ir_pc(ir_pc0), .ir_valid(ir_valid0), .busy(busy0), .fault(fault0)
  );

  ifetch_unit #(.RESET_PC(RST_PC3), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_req(fetch_req3), .ir_ack(ir_ack3),
    .pc_we(pc_we3), .pc_src(pc_src), .jr_target(jr_target), .imem_rdata(imem_rdata3),
    .pc(pc3), .ir(ir3), .ir_pc(ir_pc3), .ir_valid(ir_valid3), .busy(busy3), .fault(fault3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_pc0(input logic [31:0] target);
    pc_src    = 2'b11;
    jr_target = target;
    pc_we0    = 1'b1;
    cycle();
    pc_we0    = 1'b0;
  endtask

  task automatic ack0();
    ir_ack0 = 1'b1;
    cycle();
    ir_ack0 = 1'b0;
  endtask

  task automatic fetch0(input logic [31:0] at_pc);
    fetch_t e;
    int     n;
    sb.push_back({imem[at_pc[7:2]], at_pc});
    fetch_req0 = 1'b1;
    cycle();
    fetch_req0 = 1'b0;
    n = 0;
    while (!ir_valid0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (ir_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL fetch0_timeout ir_valid got %b expected 1", ir_valid0);
    end
    e = sb.pop_front();
    checks++;
    if (ir0 !== e.ir) begin
      errors++;
      $display("FAIL fetch0_ir got %h expected %h", ir0, e.ir);
    end
    checks++;
    if (ir_pc0 !== e.ir_pc) begin
      errors++;
      $display("FAIL fetch0_ir_pc got %h expected %h", ir_pc0, e.ir_pc);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc0 got %h expected 0", pc0); end
    checks++;
    if (pc3 !== RST_PC3) begin errors++; $display("FAIL reset_pc3 got %h expected %h", pc3, RST_PC3); end
    checks++;
    if ({ir0, ir_pc0} !== 64'h0) begin errors++; $display("FAIL reset_ir got %h/%h expected 0/0", ir0, ir_pc0); end
    checks++;
    if ({ir_valid0, busy0, fault0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000", {ir_valid0, busy0, fault0});
    end
  endtask

  // Zero latency: busy for one cycle, ir_valid two cycles after the request.
  task automatic test_basic_fetch();
    fetch_t e;
    sb.push_back({32'h2008_0005, 32'h0});
    fetch_req0 = 1'b1;
    cycle();
    fetch_req0 = 1'b0;
    checks++;
    if ({busy0, ir_valid0} !== 2'b10) begin
      errors++;
      $display("FAIL basic_wait busy/valid got %b expected 10", {busy0, ir_valid0});
    end
    cycle();
    checks++;
    if ({busy0, ir_valid0} !== 2'b01) begin
      errors++;
      $display("FAIL basic_valid busy/valid got %b expected 01", {busy0, ir_valid0});
    end
    e = sb.pop_front();
    checks++;
    if (ir0 !== e.ir) begin errors++; $display("FAIL basic_ir got %h expected %h", ir0, e.ir); end
    checks++;
    if (ir_pc0 !== e.ir_pc) begin errors++; $display("FAIL basic_ir_pc got %h expected %h", ir_pc0, e.ir_pc); end
    fetch_req0 = 1'b1;
    cycle();
    checks++;
    if ({busy0, ir_valid0} !== 2'b01) begin
      errors++;
      $display("FAIL req_in_valid busy/valid got %b expected 01", {busy0, ir_valid0});
    end
    ir_ack0 = 1'b1;
    cycle();
    ir_ack0    = 1'b0;
    fetch_req0 = 1'b0;
    checks++;
    if ({busy0, ir_valid0} !== 2'b00) begin
      errors++;
      $display("FAIL ack_with_req busy/valid got %b expected 00", {busy0, ir_valid0});
    end
  endtask

  // Latency 3: busy for four cycles, pc_we during WAIT has no effect.
  task automatic test_latency();
    fetch_t e;
    sb.push_back({imem[RST_PC3[7:2]], RST_PC3});
    fetch_req3 = 1'b1;
    cycle();
    fetch_req3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy3, ir_valid3} !== 2'b10) begin
        errors++;
        $display("FAIL lat_wait%0d busy/valid got %b expected 10", i, {busy3, ir_valid3});
      end
      pc_we3 = (i == 1);
      pc_src = 2'b00;
      cycle();
    end
    pc_we3 = 1'b0;
    checks++;
    if ({busy3, ir_valid3} !== 2'b01) begin
      errors++;
      $display("FAIL lat_valid busy/valid got %b expected 01", {busy3, ir_valid3});
    end
    checks++;
    if (pc3 !== RST_PC3) begin errors++; $display("FAIL lat_pc_held got %h expected %h", pc3, RST_PC3); end
    e = sb.pop_front();
    checks++;
    if ({ir3, ir_pc3} !== {e.ir, e.ir_pc}) begin
      errors++;
      $display("FAIL lat_ir got %h/%h expected %h/%h", ir3, ir_pc3, e.ir, e.ir_pc);
    end
    ir_ack3 = 1'b1;
    cycle();
    ir_ack3 = 1'b0;
  endtask

  task automatic test_next_pc();
    set_pc0(32'h0000_0010);
    fetch0(32'h0000_0010);
    ack0();
    pc_src = 2'b01;
    pc_we0 = 1'b1;
    cycle();
    pc_we0 = 1'b0;
    checks++;
    if (pc0 !== 32'h0000_000C) begin errors++; $display("FAIL branch_pc got %h expected 0000000c", pc0); end
    fetch0(32'h0000_000C);
    ack0();
    pc_src = 2'b10;
    pc_we0 = 1'b1;
    cycle();
    checks++;
    if (pc0 !== 32'h0000_0100) begin errors++; $display("FAIL jump_pc got %h expected 00000100", pc0); end
    pc_src = 2'b00;
    cycle();
    pc_we0 = 1'b0;
    checks++;
    if (pc0 !== 32'h0000_0104) begin errors++; $display("FAIL plus4_pc got %h expected 00000104", pc0); end
  endtask

  task automatic test_wrap_fault();
    set_pc0(32'hFFFF_FFFC);
    pc_src = 2'b00;
    pc_we0 = 1'b1;
    cycle();
    pc_we0 = 1'b0;
    checks++;
    if ({pc0, fault0} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wrap got pc %h fault %b expected 00000000 0", pc0, fault0);
    end
    set_pc0(32'h0000_0102);
    checks++;
    if ({pc0, fault0} !== {32'h0, 1'b1}) begin
      errors++;
      $display("FAIL misalign got pc %h fault %b expected 00000000 1", pc0, fault0);
    end
    set_pc0(32'h0000_0040);
    checks++;
    if ({pc0, fault0} !== {32'h40, 1'b1}) begin
      errors++;
      $display("FAIL fault_sticky got pc %h fault %b expected 00000040 1", pc0, fault0);
    end
    reset_dut();
    checks++;
    if ({pc0, fault0} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL fault_clear got pc %h fault %b expected 00000000 0", pc0, fault0);
    end
  endtask

  task automatic test_reset_mid_and_ack();
    pc_src    = 2'b11;
    jr_target = 32'h0000_0080;
    pc_we3    = 1'b1;
    cycle();
    pc_we3    = 1'b0;
    fetch_req3 = 1'b1;
    cycle();
    fetch_req3 = 1'b0;
    cycle();
    checks++;
    if ({busy3, pc3} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL pre_rst got busy %b pc %h expected 1 00000080", busy3, pc3);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({busy3, ir_valid3, pc3} !== {2'b00, RST_PC3}) begin
      errors++;
      $display("FAIL rst_in_wait got busy %b valid %b pc %h expected 0 0 %h", busy3, ir_valid3, pc3, RST_PC3);
    end
    repeat (6) cycle();
    checks++;
    if ({busy3, ir_valid3} !== 2'b00) begin
      errors++;
      $display("FAIL rst_discard got busy/valid %b expected 00", {busy3, ir_valid3});
    end
    fetch0(32'h0);
    pc_src  = 2'b00;
    pc_we0  = 1'b1;
    ir_ack0 = 1'b1;
    cycle();
    pc_we0  = 1'b0;
    ir_ack0 = 1'b0;
    checks++;
    if ({ir_valid0, pc0} !== {1'b0, 32'h4}) begin
      errors++;
      $display("FAIL ack_and_we got valid %b pc %h expected 0 00000004", ir_valid0, pc0);
    end
  endtask

  task automatic test_stall();
    fetch_t e;
    stall      = 1'b1;
    fetch_req0 = 1'b1;
    pc_we0     = 1'b1;
    pc_src     = 2'b00;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({busy0, ir_valid0, pc0} !== {2'b00, 32'h4}) begin
        errors++;
        $display("FAIL stall%0d got busy %b valid %b pc %h expected 0 0 00000004", i, busy0, ir_valid0, pc0);
      end
    end
    pc_we0 = 1'b0;
    stall  = 1'b0;
    sb.push_back({imem[1], 32'h4});
    cycle();
    fetch_req0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL stall_release busy got %b expected 1", busy0); end
    cycle();
    e = sb.pop_front();
    checks++;
    if ({ir_valid0, ir0, ir_pc0} !== {1'b1, e.ir, e.ir_pc}) begin
      errors++;
      $display("FAIL stall_fetch got %b %h/%h expected 1 %h/%h", ir_valid0, ir0, ir_pc0, e.ir, e.ir_pc);
    end
    ack0();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    stall      = 1'b0;
    pc_src     = 2'b00;
    jr_target  = 32'h0;
    fetch_req0 = 1'b0;
    ir_ack0    = 1'b0;
    pc_we0     = 1'b0;
    fetch_req3 = 1'b0;
    ir_ack3    = 1'b0;
    pc_we3     = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'hA500_0000 | 32'(i * 17);
    imem[0] = 32'h2008_0005;
    imem[3] = 32'h0800_0040;
    imem[4] = 32'h1000_FFFE;

    test_reset();
    test_basic_fetch();
    test_latency();
    test_next_pc();
    test_wrap_fault();
    test_reset_mid_and_ack();
    test_stall();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
